// File: rtl/sm4_axis128_rx_buf_if.sv
// Stream bundle for the SM4 result buffer: no-backpressure result input
// plus the buffered AXI-Stream output with tready.
interface sm4_axis128_rx_buf_if;
   logic         in_tvalid;
   logic [127:0] in_tdata;
   logic         in_tlast;
   logic [127:0] m_axis_tdata;
   logic         m_axis_tvalid;
   logic         m_axis_tlast;
   logic         m_axis_tready;

   // Environment side: drives SM4 results in, consumes the buffered stream
   modport master (
      output in_tvalid, in_tdata, in_tlast, m_axis_tready,
      input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );

   // Buffer side
   modport slave (
      input  in_tvalid, in_tdata, in_tlast, m_axis_tready,
      output m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
endinterface

// File: rtl/sm4_axis128_rx_buf.sv
// Receive buffer for SM4 results: FWFT FIFO re-presenting the result stream
// as AXI-Stream, with a credit counter that bounds upstream issue to free space.
module sm4_axis128_rx_buf #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      issue,
   output logic                      credit_ok,
   sm4_axis128_rx_buf_if.slave       s_axis,
   output logic [AW:0]               level,
   output logic [AW:0]               credits,
   output logic [1:0]                err
);

   localparam int unsigned LW   = AW + 1;
   localparam logic [AW:0] FULL = LW'(DEPTH);

   logic [128:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic [AW:0]   r_credits;
   logic          r_credit_ok;
   logic          r_tvalid;
   logic [1:0]    r_err;

   logic          w_pop;
   logic          w_full;
   logic          w_wr;
   logic          w_ovf;
   logic          w_under;
   logic [AW:0]   w_level_nxt;
   logic [AW:0]   w_credits_nxt;
   logic [128:0]  w_head;

   // A pop frees the slot in the same cycle, so a write while full is only
   // an overflow when nothing is being popped.
   always_comb begin
      w_pop         = r_tvalid & s_axis.m_axis_tready;
      w_full        = (r_level == FULL);
      w_wr          = s_axis.in_tvalid & (~w_full | w_pop);
      w_ovf         = s_axis.in_tvalid & w_full & ~w_pop;
      w_level_nxt   = r_level;
      w_credits_nxt = r_credits;
      w_under       = 1'b0;

      if (w_wr && !w_pop) begin
         w_level_nxt = r_level + LW'(1);
      end else if (!w_wr && w_pop) begin
         w_level_nxt = r_level - LW'(1);
      end

      // Credits never wrap: issue at zero credits is flagged, not counted
      if (issue && !w_pop) begin
         if (r_credits == '0) begin
            w_under = 1'b1;
         end else begin
            w_credits_nxt = r_credits - LW'(1);
         end
      end else if (w_pop && !issue && (r_credits != FULL)) begin
         w_credits_nxt = r_credits + LW'(1);
      end
   end

   // Control state; credit_ok and tvalid are registered from next-state so
   // they always agree with the registered credits/level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_credits   <= FULL;
         r_credit_ok <= 1'b1;
         r_tvalid    <= 1'b0;
         r_err       <= '0;
      end else if (flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_credits   <= FULL;
         r_credit_ok <= 1'b1;
         r_tvalid    <= 1'b0;
         r_err       <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_level     <= w_level_nxt;
         r_credits   <= w_credits_nxt;
         r_credit_ok <= (w_credits_nxt != '0);
         r_tvalid    <= (w_level_nxt != '0);
         r_err       <= r_err | {w_under, w_ovf};
      end
   end

   // Storage is intentionally left unreset
   always_ff @(posedge clk) begin
      if (w_wr && !flush) begin
         r_mem[r_wr_ptr] <= {s_axis.in_tlast, s_axis.in_tdata};
      end
   end

   assign w_head               = r_mem[r_rd_ptr];
   assign s_axis.m_axis_tdata  = w_head[127:0];
   assign s_axis.m_axis_tlast  = w_head[128];
   assign s_axis.m_axis_tvalid = r_tvalid;
   assign credit_ok            = r_credit_ok;
   assign level                = r_level;
   assign credits              = r_credits;
   assign err                  = r_err;

endmodule

// File: tb/tb_sm4_axis128_rx_buf.sv
// Self-checking bench for sm4_axis128_rx_buf: queue-based reference model,
// a 32-cycle SM4 pipeline stand-in, directed corner cases and a random soak.
module tb_sm4_axis128_rx_buf;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;
   localparam int          PIPE  = 32;
   localparam int          NRAND = 10000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush;
   logic          issue;
   logic          credit_ok;
   logic [AW:0]   level;
   logic [AW:0]   credits;
   logic [1:0]    err;

   sm4_axis128_rx_buf_if bus ();

   sm4_axis128_rx_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .issue     (issue),
      .credit_ok (credit_ok),
      .s_axis    (bus),
      .level     (level),
      .credits   (credits),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           due;
      logic [128:0] blk;
   } fl_t;

   fl_t          pipe[$];
   logic [128:0] mq[$];
   int           m_credits;
   logic [1:0]   m_err;
   int           n_out;

   logic         d_issue, d_tready, d_flush, d_force;
   logic [128:0] d_blk, d_fblk;
   bit           chk_inv;
   int           cyc;
   int           n_tests, n_fail;

   task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic compare_outputs();
      chk("m_axis_tvalid", 129'(bus.m_axis_tvalid), 129'(mq.size() != 0));
      if (mq.size() != 0)
         chk("head {tlast,tdata}", {bus.m_axis_tlast, bus.m_axis_tdata}, mq[0]);
      chk("level", 129'(level), 129'(mq.size()));
      chk("credits", 129'(credits), 129'(m_credits));
      chk("credit_ok", 129'(credit_ok), 129'(m_credits != 0));
      chk("err", 129'(err), 129'(m_err));
      if (chk_inv)
         chk("credits+level+inflight", 129'(int'(credits) + int'(level) + pipe.size()), 129'(DEPTH));
   endtask

   // One clock: check outputs, drive this cycle's inputs, advance the model
   task automatic cycle();
      bit           arr, m_pop, was_full;
      int           c;
      fl_t          f;
      logic [128:0] ablk;
      compare_outputs();
      arr  = 1'b0;
      ablk = '0;
      if (pipe.size() > 0 && pipe[0].due <= cyc) begin
         f    = pipe.pop_front();
         arr  = 1'b1;
         ablk = f.blk;
      end
      if (d_force) ablk = d_fblk;
      bus.in_tvalid     = arr | d_force;
      bus.in_tdata      = ablk[127:0];
      bus.in_tlast      = ablk[128];
      bus.m_axis_tready = d_tready;
      issue             = d_issue;
      flush             = d_flush;
      if (d_issue && !d_flush) begin
         f.due = cyc + PIPE;
         f.blk = d_blk;
         pipe.push_back(f);
      end
      if (d_flush) begin
         mq.delete();
         m_credits = DEPTH;
         m_err     = 2'b00;
      end else begin
         m_pop    = (mq.size() != 0) && d_tready;
         was_full = (mq.size() == DEPTH);
         if (m_pop) begin
            void'(mq.pop_front());
            n_out++;
         end
         if (arr || d_force) begin
            if (was_full && !m_pop) m_err[0] = 1'b1;
            else                    mq.push_back(ablk);
         end
         c = m_credits - int'(d_issue) + int'(m_pop);
         if (c < 0) begin
            c        = 0;
            m_err[1] = 1'b1;
         end
         if (c > DEPTH) c = DEPTH;
         m_credits = c;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   function automatic logic [128:0] rand_blk();
      return {1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic fill_until_no_credit(input string nm);
      int n;
      n = 0;
      d_tready = 1'b0;
      for (int k = 0; k < 200 && credit_ok; k++) begin
         d_issue = 1'b1;
         d_blk   = rand_blk();
         cycle();
         n++;
      end
      d_issue = 1'b0;
      chk(nm, 129'(n), 129'(DEPTH));
      repeat (PIPE + 8) cycle();
      chk({nm, " level full"}, 129'(level), 129'(64));
      chk({nm, " credits zero"}, 129'(credits), 129'(0));
   endtask

   initial begin
      int sent, base;
      n_tests = 0; n_fail = 0; cyc = 0; n_out = 0;
      m_credits = DEPTH; m_err = 2'b00; chk_inv = 1'b0;
      d_issue = 0; d_tready = 0; d_flush = 0; d_force = 0; d_blk = '0; d_fblk = '0;
      issue = 0; flush = 0;
      bus.in_tvalid = 0; bus.in_tdata = '0; bus.in_tlast = 0; bus.m_axis_tready = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset values
      chk("rst credits", 129'(credits), 129'(64));
      chk("rst credit_ok", 129'(credit_ok), 129'(1));
      chk("rst level", 129'(level), 129'(0));
      chk("rst tvalid", 129'(bus.m_axis_tvalid), 129'(0));
      chk("rst err", 129'(err), 129'(0));

      // Ten ordered blocks, tlast on the last one
      chk_inv  = 1'b1;
      d_tready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         d_issue = 1'b1;
         d_blk   = {(i == 9), 128'(i)};
         cycle();
      end
      d_issue = 1'b0;
      repeat (PIPE + 12) cycle();
      chk("ten blocks out", 129'(n_out), 129'(10));
      chk("ten credits back", 129'(credits), 129'(64));

      // Fill to zero credits, then drain
      fill_until_no_credit("stall issues");
      d_tready = 1'b1;
      cycle();
      chk("first pop credit_ok", 129'(credit_ok), 129'(1));
      chk("first pop credits", 129'(credits), 129'(1));
      chk("first pop level", 129'(level), 129'(63));
      repeat (70) cycle();
      chk("drain level", 129'(level), 129'(0));
      chk("drain credits", 129'(credits), 129'(64));

      // Full FIFO: write with pop accepted, write without pop dropped
      fill_until_no_credit("refill issues");
      chk_inv  = 1'b0;
      d_tready = 1'b1;
      d_force  = 1'b1;
      d_fblk   = rand_blk();
      cycle();
      d_tready = 1'b0;
      d_force  = 1'b0;
      chk("full+pop level", 129'(level), 129'(64));
      chk("full+pop err", 129'(err), 129'(0));
      d_force = 1'b1;
      d_fblk  = rand_blk();
      cycle();
      d_force = 1'b0;
      chk("overflow level", 129'(level), 129'(64));
      chk("overflow err", 129'(err), 129'(1));
      d_flush = 1'b1;
      cycle();
      d_flush = 1'b0;

      // Issue at zero credits, then flush with issue and pop both asserted
      fill_until_no_credit("underflow fill");
      d_issue = 1'b1;
      d_blk   = rand_blk();
      cycle();
      d_issue = 1'b0;
      chk("underflow credits", 129'(credits), 129'(0));
      chk("underflow err", 129'(err), 129'(2));
      repeat (PIPE + 8) cycle();
      d_flush  = 1'b1;
      d_issue  = 1'b1;
      d_tready = 1'b1;
      cycle();
      d_flush  = 1'b0;
      d_issue  = 1'b0;
      d_tready = 1'b0;
      chk("flush credits", 129'(credits), 129'(64));
      chk("flush level", 129'(level), 129'(0));
      chk("flush err", 129'(err), 129'(0));
      chk("flush tvalid", 129'(bus.m_axis_tvalid), 129'(0));

      // Random soak: 50% tready, issue whenever a credit is free
      chk_inv = 1'b1;
      sent    = 0;
      base    = n_out;
      for (int k = 0; k < 40000 && (n_out - base) < NRAND; k++) begin
         d_tready = 1'($urandom_range(0, 1));
         d_issue  = credit_ok && (sent < NRAND);
         d_blk    = rand_blk();
         if (d_issue) sent++;
         cycle();
      end
      d_issue = 1'b0;
      cycle();
      chk("soak blocks out", 129'(n_out - base), 129'(NRAND));
      chk("soak err", 129'(err), 129'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
